// File: rtl/neopixel_tx.sv
// WS2812-style single-wire LED transmitter: 24-bit GRB words in over valid/ready,
// MSB-first pulse-width coded bits out, plus an on-demand low latch code.
module neopixel_tx #(
  parameter int T0H_CNT = 16,
  parameter int T0L_CNT = 44,
  parameter int T1H_CNT = 40,
  parameter int T1L_CNT = 20,
  parameter int RST_CNT = 15000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        latch_i,
  output logic        bit_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int MAX_A   = (T0H_CNT > T0L_CNT) ? T0H_CNT : T0L_CNT;
  localparam int MAX_B   = (T1H_CNT > T1L_CNT) ? T1H_CNT : T1L_CNT;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CNT = (MAX_AB > RST_CNT) ? MAX_AB : RST_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  // Counters load N-1 and count down to 0, so each period is exactly N cycles.
  localparam logic [CW-1:0] T0H_LD = CW'(T0H_CNT - 1);
  localparam logic [CW-1:0] T0L_LD = CW'(T0L_CNT - 1);
  localparam logic [CW-1:0] T1H_LD = CW'(T1H_CNT - 1);
  localparam logic [CW-1:0] T1L_LD = CW'(T1L_CNT - 1);
  localparam logic [CW-1:0] RST_LD = CW'(RST_CNT - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, RESET} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] shreg;
  logic [4:0]  bit_cnt;
  logic [CW-1:0] cnt;
  logic        period_end;
  logic        word_end;
  logic        xfer;
  logic        bit_nxt;
  logic        done_nxt;

  function automatic logic [CW-1:0] high_load(input logic b);
    return b ? T1H_LD : T0H_LD;
  endfunction

  function automatic logic [CW-1:0] low_load(input logic b);
    return b ? T1L_LD : T0L_LD;
  endfunction

  assign period_end = (cnt == '0);
  assign word_end   = (state == LOW) && (bit_cnt == 5'd0) && period_end;
  assign ready_o    = !rst_i && ((state == IDLE) || word_end);
  assign xfer       = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      bit_o  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      bit_o  <= bit_nxt;
      done_o <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xfer)         state_nxt = HIGH;
        else if (latch_i) state_nxt = RESET;
      end
      HIGH: begin
        if (period_end) state_nxt = LOW;
      end
      LOW: begin
        if (period_end) begin
          if (bit_cnt != 5'd0) state_nxt = HIGH;
          else if (xfer)       state_nxt = HIGH;
          else                 state_nxt = IDLE;
        end
      end
      RESET: begin
        if (period_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_o and done_o are registered from the next state so the pin follows the FSM without glitches.
  always_comb begin
    busy_o   = (state != IDLE);
    bit_nxt  = (state_nxt == HIGH);
    done_nxt = (state == RESET) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg   <= data_i;
            bit_cnt <= 5'd23;
            cnt     <= high_load(data_i[23]);
          end else if (latch_i) begin
            cnt <= RST_LD;
          end
        end
        HIGH: begin
          if (period_end) cnt <= low_load(shreg[23]);
          else            cnt <= cnt - CW'(1);
        end
        LOW: begin
          if (period_end) begin
            if (bit_cnt != 5'd0) begin
              shreg   <= {shreg[22:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
              cnt     <= high_load(shreg[22]);
            end else if (xfer) begin
              shreg   <= data_i;
              bit_cnt <= 5'd23;
              cnt     <= high_load(data_i[23]);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESET: begin
          if (!period_end) cnt <= cnt - CW'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_tx.sv
// Directed bench for neopixel_tx: a negedge monitor decodes bit_o into words and
// the main sequence compares them against words queued when each was sent.
module tb_neopixel_tx;

  localparam int T0H = 2;
  localparam int T0L = 6;
  localparam int T1H = 5;
  localparam int T1L = 3;
  localparam int RST = 10;
  localparam int BIT_PERIOD = T0H + T0L;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data;
  logic        valid;
  logic        ready;
  logic        latch;
  logic        bit_out;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;
  int abort_req = 0;
  int width_errs = 0;

  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];

  neopixel_tx #(
    .T0H_CNT(T0H), .T0L_CNT(T0L), .T1H_CNT(T1H), .T1L_CNT(T1L), .RST_CNT(RST)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
    .latch_i(latch), .bit_o(bit_out), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Decodes the serial line: high width picks the bit value, gaps within a word must be exact.
  logic        m_prev = 1'b0;
  logic        m_ignore = 1'b0;
  logic        m_have_last = 1'b0;
  int          m_hcnt = 0;
  int          m_lcnt = 0;
  int          m_last_h = 0;
  int          m_nbits = 0;
  int          m_abort_seen = 0;
  logic [23:0] m_word = '0;

  always @(negedge clk) begin
    if (m_abort_seen != abort_req) begin
      m_abort_seen = abort_req;
      m_ignore = 1'b1;
      m_nbits = 0;
      m_have_last = 1'b0;
    end
    if (m_ignore) begin
      if (bit_out === 1'b0) begin
        m_ignore = 1'b0;
        m_prev = 1'b0;
      end
    end else if (bit_out === 1'b1) begin
      if (!m_prev) begin
        if (m_have_last) begin
          if (m_nbits != 0 && m_lcnt != BIT_PERIOD - m_last_h) width_errs++;
          if (m_nbits == 0 && m_lcnt < BIT_PERIOD - m_last_h) width_errs++;
        end
        m_have_last = 1'b0;
        m_hcnt = 1;
      end else begin
        m_hcnt++;
      end
      m_prev = 1'b1;
    end else begin
      if (m_prev) begin
        if (m_hcnt != T0H && m_hcnt != T1H) width_errs++;
        m_word = {m_word[22:0], (m_hcnt == T1H)};
        m_nbits++;
        if (m_nbits == 24) begin
          got_q.push_back(m_word);
          m_nbits = 0;
        end
        m_last_h = m_hcnt;
        m_lcnt = 1;
        m_have_last = 1'b1;
      end else if (m_have_last) begin
        m_lcnt++;
      end
      m_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] d, input logic v, input logic l);
    data  = d;
    valid = v;
    latch = l;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts samples with busy high; optionally scrambles data_i while the frame is in flight.
  task automatic wait_idle(input bit scramble, output int n);
    n = 0;
    while (busy === 1'b1 && n < 800) begin
      n++;
      if (scramble) data = 24'($urandom);
      tick(1);
    end
  endtask

  task automatic drain(input string tag);
    logic [23:0] g;
    logic [23:0] e;
    checkOutput({tag, "_word_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_word"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    applyStimulus(24'h0, 1'b0, 1'b0);
    tick(2);
    checkOutput("reset_ready_forced_low", ready, 0);
    checkOutput("reset_bit", bit_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", ready, 1);

    // One word with mixed bit values.
    $display("[TB] single word 0x800001");
    applyStimulus(24'h800001, 1'b1, 1'b0);
    exp_q.push_back(24'h800001);
    tick(1);
    applyStimulus(24'h0, 1'b0, 1'b0);
    checkOutput("first_bit_high", bit_out, 1);
    checkOutput("busy_in_frame", busy, 1);
    checkOutput("ready_low_in_frame", ready, 0);
    wait_idle(1'b0, n);
    checkOutput("single_busy_cycles", n, 192);
    checkOutput("single_ready_after", ready, 1);
    checkOutput("single_bit_after", bit_out, 0);
    drain("single");

    // Two gapless words with valid held.
    $display("[TB] back-to-back 0xFFFFFF, 0x000000");
    applyStimulus(24'hFFFFFF, 1'b1, 1'b0);
    exp_q.push_back(24'hFFFFFF);
    tick(1);
    applyStimulus(24'h000000, 1'b1, 1'b0);
    exp_q.push_back(24'h000000);
    bad = 0;
    for (int i = 1; i <= 190; i++) begin
      tick(1);
      if (busy !== 1'b1) bad++;
    end
    checkOutput("b2b_busy_drops", bad, 0);
    checkOutput("b2b_ready_early", ready, 0);
    tick(1);
    checkOutput("b2b_ready_last_cycle", ready, 1);
    checkOutput("b2b_bit_last_low", bit_out, 0);
    checkOutput("b2b_busy_last", busy, 1);
    tick(1);
    applyStimulus(24'h0, 1'b0, 1'b0);
    checkOutput("b2b_second_rise", bit_out, 1);
    checkOutput("b2b_busy_boundary", busy, 1);
    wait_idle(1'b0, n);
    checkOutput("b2b_second_busy_cycles", n, 192);
    drain("b2b");

    // Latch code, with valid ignored while it runs.
    $display("[TB] latch code");
    applyStimulus(24'h0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(24'hABCDEF, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < RST; i++) begin
      if (bit_out !== 1'b0 || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) bad++;
      if (i == RST - 1) valid = 1'b0;
      else tick(1);
    end
    checkOutput("latch_reset_phase", bad, 0);
    tick(1);
    checkOutput("latch_done_pulse", done, 1);
    checkOutput("latch_idle_busy", busy, 0);
    tick(1);
    checkOutput("latch_done_one_cycle", done, 0);
    checkOutput("latch_no_word", got_q.size(), 0);

    // valid and latch together: data wins, held latch runs after the word.
    $display("[TB] valid and latch together");
    applyStimulus(24'h5A5A5A, 1'b1, 1'b1);
    exp_q.push_back(24'h5A5A5A);
    tick(1);
    applyStimulus(24'h0, 1'b0, 1'b1);
    checkOutput("both_word_wins", bit_out, 1);
    bad = 0;
    for (int i = 1; i <= 191; i++) begin
      tick(1);
      if (done !== 1'b0 || busy !== 1'b1) bad++;
    end
    checkOutput("both_no_done_in_frame", bad, 0);
    tick(1);
    checkOutput("both_idle_after_word", busy, 0);
    tick(1);
    checkOutput("both_latch_busy", busy, 1);
    checkOutput("both_latch_ready", ready, 0);
    latch = 1'b0;
    tick(RST);
    checkOutput("both_latch_done", done, 1);
    drain("both");

    // Reset mid-word, then a clean word.
    $display("[TB] reset mid-word");
    applyStimulus(24'h123456, 1'b1, 1'b0);
    tick(1);
    valid = 1'b0;
    tick(5 * BIT_PERIOD);
    checkOutput("abort_in_high", bit_out, 1);
    rst = 1'b1;
    abort_req++;
    tick(1);
    checkOutput("abort_ready_forced", ready, 0);
    rst = 1'b0;
    checkOutput("abort_bit", bit_out, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    #1;
    checkOutput("abort_ready_after", ready, 1);
    applyStimulus(24'h0F0F0F, 1'b1, 1'b0);
    exp_q.push_back(24'h0F0F0F);
    tick(1);
    valid = 1'b0;
    wait_idle(1'b0, n);
    checkOutput("abort_next_busy_cycles", n, 192);
    checkOutput("abort_no_done", done, 0);
    drain("abort");

    // data_i scrambled every cycle after the transfer.
    $display("[TB] data toggling during frame");
    applyStimulus(24'hC3A55A, 1'b1, 1'b0);
    exp_q.push_back(24'hC3A55A);
    tick(1);
    valid = 1'b0;
    wait_idle(1'b1, n);
    checkOutput("toggle_busy_cycles", n, 192);
    drain("toggle");

    tick(30);
    checkOutput("stray_words", got_q.size(), 0);
    checkOutput("pulse_widths", width_errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/neopixel_tx.md
Name: neopixel_tx

Overview:
Serial WS2812-style LED line transmitter. It takes 24-bit pixel words over a valid/ready handshake and drives the single-wire output. Each bit is sent MSB first as a high pulse followed by a low pulse, with the widths set by cycle-count parameters. On request it also drives the low-level latch/reset code. It sits between the pixel buffer/frame sequencer and the LED output pin.

Parameters:
T0H_CNT, 16, high-time cycles for a 0 bit (>=1)
T0L_CNT, 44, low-time cycles for a 0 bit (>=1)
T1H_CNT, 40, high-time cycles for a 1 bit (>=1)
T1L_CNT, 20, low-time cycles for a 1 bit (>=1)
RST_CNT, 15000, low-time cycles of the latch code (>=1)

Ports:
clk_i  in  1  clock; all logic is on its rising edge
rst_i  in  1  synchronous, active-high reset
data_i  in  24  pixel word (GRB order, bit 23 sent first)
valid_i  in  1  data_i valid
ready_o  out  1  block can accept data_i this cycle
latch_i  in  1  request the latch/reset code
bit_o  out  1  serial LED output, registered
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when the latch code completes

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous and active-high.
- Reset values: state=IDLE, bit_o=0, busy_o=0, done_o=0, shift register=0, counters=0.
- ready_o is forced to 0 in any cycle where rst_i=1.
- States:
  - IDLE: bit_o=0.
  - HIGH: bit_o=1.
  - LOW: bit_o=0.
  - RESET: bit_o=0, emitting the latch code.
- Transfer occurs when valid_i && ready_o are sampled high at a clock edge.
- ready_o = (state==IDLE) || (state==LOW && bit_cnt==0 && last cycle of the LOW period). ready_o is combinational from state and counters.
- Transfer at edge k:
  - shift register <= data_i, bit_cnt <= 23, state <= HIGH.
  - bit_o=1 from cycle k+1 (one cycle of latency).
- HIGH period:
  - Lasts T1H_CNT cycles if the current MSB is 1, else T0H_CNT cycles.
  - Then LOW for T1L_CNT or T0L_CNT cycles.
  - One bit period is exactly TxH+TxL cycles, with no extra cycles between bits.
- End of each LOW period:
  - If bit_cnt != 0: shift left by 1, bit_cnt decrements, go to HIGH.
  - If bit_cnt == 0 and a transfer occurs: load the new word, go to HIGH. The stream is gapless.
  - If bit_cnt == 0 and no transfer occurs: go to IDLE.
- Latch code:
  - In IDLE with latch_i=1 and no transfer: go to RESET for exactly RST_CNT cycles with bit_o=0.
  - Then return to IDLE. done_o=1 in the first IDLE cycle only.
- Simultaneous valid_i && latch_i in IDLE: the data transfer wins and latch_i is ignored. The requester must hold latch_i.
- latch_i outside IDLE is ignored; it is not queued.
- valid_i while ready_o=0 is ignored. Changes to data_i after the transfer do not affect the bit in flight.
- Counters:
  - Sized to hold max(all *_CNT) and count down to 0.
  - Load value is N-1 so the period is exactly N cycles.
  - No wrap-around is possible.
- rst_i during HIGH, LOW or RESET:
  - Next cycle: IDLE, bit_o=0, no done_o pulse. The partial word is discarded.
  - ready_o=1 from the first cycle with rst_i=0.

Test Plan:
Shared setup: parameters T0H=2, T0L=6, T1H=5, T1L=3, RST=10.
1. Send one word 0x800001 with valid_i for 1 cycle in IDLE:
   - bit 23: bit_o high 5, low 3.
   - bits 22..1: high 2, low 6 each.
   - bit 0: high 5, low 3.
   - busy_o high for 192 cycles, then IDLE with ready_o=1.
2. Hold valid_i for two words 0xFFFFFF then 0x000000:
   - Second word accepted on cycle 191 of the first.
   - Second word's first rise exactly 192 cycles after the first word's.
   - busy_o never drops between words.
3. latch_i pulse in IDLE:
   - bit_o=0, busy_o=1, ready_o=0 for 10 cycles.
   - done_o=1 for exactly 1 cycle on the next (IDLE) cycle.
   - valid_i during RESET is not accepted.
4. valid_i and latch_i both high in IDLE:
   - Word accepted; no RESET entered and no done_o.
   - latch_i held through the frame enters RESET after the word ends.
5. rst_i asserted for 1 cycle during the HIGH phase of bit 5:
   - Next cycle bit_o=0, busy_o=0, no done_o.
   - A following word 0x0F0F0F is transmitted complete and correct.
6. Toggle data_i every cycle during a frame:
   - bit_o waveform matches the word sampled at transfer only.
